plc_input_conditioner: RTL and testbench

Input conditioning stage for a field input rung, between the raw FPGA pin and the ladder-logic Counter/Timer blocks. It synchronizes the asynchronous input, debounces it against a runtime-programmable stable time, and produces a clean level plus single-cycle rise/fall strobes. OUT drives the Counter's IN directly; RISE/FALL serve blocks that need pulses.

---
 rtl/plc_io_pkg.sv | 15 +
 rtl/plc_input_conditioner_if.sv | 31 +++
 rtl/plc_sync.sv | 29 ++
 rtl/plc_input_conditioner.sv | 130 +++++++++++++
 tb/tb_plc_input_conditioner.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plc_io_pkg.sv
// Shared definitions for the PLC field-input blocks: debounce state encoding
// and default build constants.
package plc_io_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } plc_state_t;

    localparam int PLC_SYNC_STAGES_DEF = 2;
    localparam int PLC_DEBOUNCE_W_DEF  = 20;

endpackage

// File: rtl/plc_input_conditioner_if.sv
// Signal bundle between a field-input conditioner and its user.
// PLC_IN_GLITCH_CNT_EN adds the glitch counter readout and its clear input.
interface plc_input_conditioner_if
    import plc_io_pkg::*;
#(
    parameter int DEBOUNCE_W = PLC_DEBOUNCE_W_DEF
);
    logic                  din;
    logic                  en;
    logic [DEBOUNCE_W-1:0] db_time;
    logic                  out;
    logic                  rise;
    logic                  fall;
    logic                  busy;

`ifdef PLC_IN_GLITCH_CNT_EN
    logic                  glitch_clr;
    logic [15:0]           glitch_cnt;

    modport master (output din, en, db_time, glitch_clr,
                    input  out, rise, fall, busy, glitch_cnt);
    modport slave  (input  din, en, db_time, glitch_clr,
                    output out, rise, fall, busy, glitch_cnt);
`else
    modport master (output din, en, db_time,
                    input  out, rise, fall, busy);
    modport slave  (input  din, en, db_time,
                    output out, rise, fall, busy);
`endif

endinterface

// File: rtl/plc_sync.sv
// N-flop synchronizer for asynchronous field inputs; all stages clear to 0.
module plc_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [N-1:0] stage_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    stage_reg[gi] <= d;
                end else begin
                    stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi - 1];
                end
            end
        end
    endgenerate

    assign q = stage_reg[N-1];

endmodule

// File: rtl/plc_input_conditioner.sv
// Synchronizes and debounces one field input, producing a clean level plus
// rise/fall strobes. PLC_IN_GLITCH_CNT_EN adds a saturating glitch counter.
module plc_input_conditioner
    import plc_io_pkg::*;
#(
    parameter int SYNC_STAGES = PLC_SYNC_STAGES_DEF,
    parameter int DEBOUNCE_W  = PLC_DEBOUNCE_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    plc_input_conditioner_if.slave  bus
);
    logic                  sin;
    plc_state_t            state_reg, state_next;
    logic [DEBOUNCE_W-1:0] cnt_reg, cnt_next;
    logic                  out_reg, out_next;
    logic                  rise_reg, rise_next;
    logic                  fall_reg, fall_next;
    logic                  busy_reg, busy_next;

    plc_sync #(.N(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.din),
        .q   (sin)
    );

`ifdef PLC_IN_GLITCH_CNT_EN
    logic        glitch_inc;
    logic [15:0] glitch_cnt_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= STABLE_LO;
            cnt_reg   <= '0;
            out_reg   <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            busy_reg  <= busy_next;
        end
    end

    // Abort (EN low, then sin reverting) outranks the threshold commit.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
`ifdef PLC_IN_GLITCH_CNT_EN
        glitch_inc = 1'b0;
`endif
        case (state_reg)
            STABLE_LO: begin
                if (bus.en && sin) begin
                    state_next = PEND_HI;
                    cnt_next   = '0;
                end
            end
            PEND_HI: begin
                if (!bus.en) begin
                    state_next = STABLE_LO;
                end else if (!sin) begin
                    state_next = STABLE_LO;
`ifdef PLC_IN_GLITCH_CNT_EN
                    glitch_inc = 1'b1;
`endif
                end else if (cnt_reg >= bus.db_time) begin
                    state_next = STABLE_HI;
                    out_next   = 1'b1;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STABLE_HI: begin
                if (bus.en && !sin) begin
                    state_next = PEND_LO;
                    cnt_next   = '0;
                end
            end
            PEND_LO: begin
                if (!bus.en) begin
                    state_next = STABLE_HI;
                end else if (sin) begin
                    state_next = STABLE_HI;
`ifdef PLC_IN_GLITCH_CNT_EN
                    glitch_inc = 1'b1;
`endif
                end else if (cnt_reg >= bus.db_time) begin
                    state_next = STABLE_LO;
                    out_next   = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = STABLE_LO;
        endcase
        busy_next = (state_next == PEND_HI) || (state_next == PEND_LO);
    end

`ifdef PLC_IN_GLITCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt_reg <= '0;
        end else if (bus.glitch_clr) begin
            glitch_cnt_reg <= '0;
        end else if (glitch_inc && (glitch_cnt_reg != 16'hFFFF)) begin
            glitch_cnt_reg <= glitch_cnt_reg + 16'd1;
        end
    end

    assign bus.glitch_cnt = glitch_cnt_reg;
`endif

    assign bus.out  = out_reg;
    assign bus.rise = rise_reg;
    assign bus.fall = fall_reg;
    assign bus.busy = busy_reg;

endmodule

// File: tb/tb_plc_input_conditioner.sv
// Randomized and directed bench for plc_input_conditioner against a run-length
// debounce model; define PLC_IN_GLITCH_CNT_EN to also check the glitch counter.
module tb_plc_input_conditioner;
    import plc_io_pkg::*;

    localparam int S  = 2;
    localparam int DW = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic glitch_clr = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    plc_input_conditioner_if #(.DEBOUNCE_W(DW)) bus ();

`ifdef PLC_IN_GLITCH_CNT_EN
    assign bus.glitch_clr = glitch_clr;
`endif

    plc_input_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: the output flips once the synchronized input has disagreed with
    // it for DB_TIME+2 consecutive enabled edges; anything else resets the run.
    typedef struct {
        logic       out;
        logic       rise;
        logic       fall;
        logic       busy;
        int         run;
        int         glitch;
        logic [3:0] hist;
    } m_t;

    m_t m;

    function automatic m_t step(m_t c, logic din, logic en, int db, logic clr);
        m_t   n;
        logic sin;
        n      = c;
        sin    = c.hist[S-1];
        n.hist = {c.hist[2:0], din};
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (en && (sin != c.out)) begin
            n.run = c.run + 1;
            if (n.run >= db + 2) begin
                n.out  = ~c.out;
                n.rise = ~c.out;
                n.fall = c.out;
                n.run  = 0;
            end
        end else begin
            if (en && c.run > 0 && c.glitch < 65535) n.glitch = c.glitch + 1;
            n.run = 0;
        end
        if (clr) n.glitch = 0;
        n.busy = (n.run > 0);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{out: 1'b0, rise: 1'b0, fall: 1'b0, busy: 1'b0,
                        run: 0, glitch: 0, hist: 4'b0};
        else     m <= step(m, bus.din, bus.en, int'(bus.db_time), glitch_clr);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.din = 1'b0;
        bus.en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.din = 1'b0;
        bus.en = 1'b1;
        bus.db_time = DW'(3);
        repeat (2) @(negedge clk);
        tests_run++;
        if ({bus.out, bus.rise, bus.fall, bus.busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bus.out, bus.rise, bus.fall, bus.busy});
        end
`ifdef PLC_IN_GLITCH_CNT_EN
        tests_run++;
        if (bus.glitch_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_glitch: got %0d expected 0", bus.glitch_cnt);
        end
`endif
        rst = 1'b0;
        $display("[TB] test_reset done");
    endtask

    task automatic test_rise_basic();
        int rise_idx = -1;
        int busy_idx = -1;
        int rises = 0;
        do_reset();
        bus.db_time = DW'(3);
        repeat (3) @(negedge clk);
        bus.din = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.out, bus.rise, bus.fall, bus.busy} !== {m.out, m.rise, m.fall, m.busy}) begin
                tests_failed++;
                $display("FAIL rise_basic cyc %0d: got %b expected %b", i,
                         {bus.out, bus.rise, bus.fall, bus.busy}, {m.out, m.rise, m.fall, m.busy});
            end
            if (bus.rise) begin rises++; if (rise_idx < 0) rise_idx = i; end
            if (bus.busy && busy_idx < 0) busy_idx = i;
        end
        tests_run++;
        if (rises != 1 || rise_idx != S + 3 + 1 || busy_idx != S) begin
            tests_failed++;
            $display("FAIL rise_latency: got rises=%0d at %0d busy at %0d expected 1 at %0d busy at %0d",
                     rises, rise_idx, busy_idx, S + 4, S);
        end
        $display("[TB] test_rise_basic done");
    endtask

    task automatic test_glitch();
        do_reset();
        bus.db_time = DW'(5);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            bus.din = (i < 4);
            @(negedge clk);
            tests_run++;
            if ({bus.out, bus.rise, bus.fall, bus.busy} !== {m.out, m.rise, m.fall, m.busy}) begin
                tests_failed++;
                $display("FAIL glitch cyc %0d: got %b expected %b", i,
                         {bus.out, bus.rise, bus.fall, bus.busy}, {m.out, m.rise, m.fall, m.busy});
            end
        end
        tests_run++;
        if (bus.out !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_out: got %b expected 0", bus.out);
        end
`ifdef PLC_IN_GLITCH_CNT_EN
        tests_run++;
        if (bus.glitch_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL glitch_cnt: got %0d expected 1", bus.glitch_cnt);
        end
`endif
        $display("[TB] test_glitch done");
    endtask

    task automatic test_fall_live_db();
        int guard = 0;
        do_reset();
        bus.db_time = DW'(8);
        bus.din = 1'b1;
        while (bus.out !== 1'b1 && guard < 40) begin @(negedge clk); guard++; end
        bus.din = 1'b0;
        // Run length 4 means the pending counter holds 3.
        while (m.run != 4 && guard < 80) begin @(negedge clk); guard++; end
        tests_run++;
        if (guard >= 80 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL fall_setup: got busy=%b guard=%0d expected busy=1", bus.busy, guard);
        end
        bus.db_time = DW'(1);
        @(negedge clk);
        tests_run++;
        if ({bus.out, bus.rise, bus.fall, bus.busy} !== 4'b0010 ||
            {m.out, m.rise, m.fall, m.busy} !== 4'b0010) begin
            tests_failed++;
            $display("FAIL fall_live_db: got %b expected 0010",
                     {bus.out, bus.rise, bus.fall, bus.busy});
        end
        @(negedge clk);
        tests_run++;
        if (bus.fall !== 1'b0 || bus.out !== 1'b0) begin
            tests_failed++;
            $display("FAIL fall_single: got fall=%b out=%b expected 0 0", bus.fall, bus.out);
        end
        $display("[TB] test_fall_live_db done");
    endtask

    task automatic test_en_gating();
        int cyc = -1;
        do_reset();
        bus.db_time = DW'(4);
        bus.din = 1'b1;
        repeat (S + 3) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.out, bus.rise} !== 3'b000) begin
            tests_failed++;
            $display("FAIL en_abort: got busy/out/rise=%b expected 000", {bus.busy, bus.out, bus.rise});
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if ({bus.busy, bus.out} !== 2'b00 || m.out !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_hold: got busy/out=%b expected 00", {bus.busy, bus.out});
        end
        bus.en = 1'b1;
        for (int i = 1; i <= 20 && cyc < 0; i++) begin
            @(negedge clk);
            if (bus.rise) cyc = i;
        end
        tests_run++;
        if (cyc != 4 + 2) begin
            tests_failed++;
            $display("FAIL en_reenable: got rise after %0d cycles expected %0d", cyc, 4 + 2);
        end
        $display("[TB] test_en_gating done");
    endtask

    task automatic test_reset_mid();
        int cyc = -1;
        do_reset();
        bus.db_time = DW'(3);
        bus.din = 1'b1;
        repeat (S + 3) @(negedge clk);
        tests_run++;
        if (bus.busy !== 1'b1 || m.run != 3) begin
            tests_failed++;
            $display("FAIL rst_mid_setup: got busy=%b run=%0d expected 1 3", bus.busy, m.run);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.out, bus.rise, bus.fall, bus.busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rst_async: got %b expected 0000", {bus.out, bus.rise, bus.fall, bus.busy});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 20 && cyc < 0; i++) begin
            @(negedge clk);
            if (bus.rise) cyc = i;
        end
        tests_run++;
        if (cyc != S + 3 + 2) begin
            tests_failed++;
            $display("FAIL rst_mid_latency: got %0d edges expected %0d", cyc, S + 3 + 2);
        end
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_chain();
        int acc = 0;
        logic dn;
        logic pattern[$];
        do_reset();
        bus.db_time = DW'(2);
        for (int p = 0; p < 3; p++) begin
            pattern.push_back(1'b1); pattern.push_back(1'b0);
            pattern.push_back(1'b1); pattern.push_back(1'b0);
            for (int i = 0; i < 10; i++) pattern.push_back(1'b1);
            pattern.push_back(1'b0); pattern.push_back(1'b1);
            pattern.push_back(1'b0); pattern.push_back(1'b1);
            for (int i = 0; i < 10; i++) pattern.push_back(1'b0);
        end
        while (pattern.size() > 0) begin
            bus.din = pattern.pop_front();
            @(negedge clk);
            if (bus.rise) acc++;
        end
        repeat (8) @(negedge clk);
        dn = (acc >= 3);
        tests_run++;
        if (acc != 3 || dn !== 1'b1) begin
            tests_failed++;
            $display("FAIL chain_counter: got ACC=%0d DN=%b expected ACC=3 DN=1", acc, dn);
        end
        $display("[TB] test_chain done");
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) bus.db_time = DW'($urandom_range(0, 6));
            if ($urandom_range(0, 99) < 15) bus.din = ~bus.din;
            bus.en = ($urandom_range(0, 99) < 92);
            glitch_clr = ($urandom_range(0, 99) < 2);
            @(negedge clk);
            tests_run++;
            if ({bus.out, bus.rise, bus.fall, bus.busy} !== {m.out, m.rise, m.fall, m.busy}) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("FAIL random cyc %0d: got %b expected %b", i,
                             {bus.out, bus.rise, bus.fall, bus.busy}, {m.out, m.rise, m.fall, m.busy});
            end
`ifdef PLC_IN_GLITCH_CNT_EN
            tests_run++;
            if (int'(bus.glitch_cnt) != m.glitch) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_glitch cyc %0d: got %0d expected %0d", i, bus.glitch_cnt, m.glitch);
            end
`endif
        end
        glitch_clr = 1'b0;
        bus.en = 1'b1;
        $display("[TB] test_random done");
    endtask

    initial begin
        bus.din = 1'b0;
        bus.en = 1'b1;
        bus.db_time = '0;
        test_reset();
        test_rise_basic();
        test_glitch();
        test_fall_live_db();
        test_en_gating();
        test_reset_mid();
        test_chain();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
